// File: rtl/flag_status_register_if.sv
// ALU-side bundle for the flag status register.
// Master drives operands and control; slave returns flags.
interface flag_status_register_if #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 8
);
    logic                   In_Valid;
    logic                   Enable;
    logic                   Selection_Sum_Sub;
    logic                   Unsigned_Mode;
    logic [WIDTH-1:0]       Operand_A;
    logic [WIDTH-1:0]       Operand_B;
    logic [WIDTH-1:0]       Result;
    logic                   Carry_Out;
    logic                   Flags_Write;
    logic [3:0]             Flags_In;
    logic                   Clear_Sticky;
    logic                   Out_Valid;
    logic                   Zero;
    logic                   Negative;
    logic                   Carry;
    logic                   Overflow;
    logic                   Overflow_Sticky;
    logic [COUNT_WIDTH-1:0] Overflow_Count;

    modport master (
        output In_Valid, Enable, Selection_Sum_Sub,
        output Unsigned_Mode, Operand_A, Operand_B,
        output Result, Carry_Out, Flags_Write,
        output Flags_In, Clear_Sticky,
        input  Out_Valid, Zero, Negative, Carry,
        input  Overflow, Overflow_Sticky, Overflow_Count
    );

    modport slave (
        input  In_Valid, Enable, Selection_Sum_Sub,
        input  Unsigned_Mode, Operand_A, Operand_B,
        input  Result, Carry_Out, Flags_Write,
        input  Flags_In, Clear_Sticky,
        output Out_Valid, Zero, Negative, Carry,
        output Overflow, Overflow_Sticky, Overflow_Count
    );
endinterface

// File: rtl/flag_status_register.sv
// Registered Z/N/C/V flags for an ALU result, with a
// sticky overflow bit and a saturating overflow counter.
module flag_status_register #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 8
) (
    input logic                   Clock,
    input logic                   Reset,
    flag_status_register_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [3:0]             flags_d, flags_q;
    logic                   sticky_d, sticky_q;
    logic [COUNT_WIDTH-1:0] count_d, count_q;
    logic                   valid_d, valid_q;

    logic sa, sb, sr;
    logic z, n, c, v_s, v;
    logic capture;

    always_comb begin
        sa = bus.Operand_A[WIDTH-1];
        sb = bus.Operand_B[WIDTH-1];
        sr = bus.Result[WIDTH-1];
        z  = (bus.Result == '0);
        n  = sr;
        // Subtraction inverts carry so C reads as borrow.
        c  = bus.Enable &
             (bus.Selection_Sum_Sub ? ~bus.Carry_Out
                                    : bus.Carry_Out);
        if (bus.Selection_Sum_Sub)
            v_s = (sa != sb) && (sr != sa);
        else
            v_s = (sa == sb) && (sr != sa);
        v = bus.Enable &
            (bus.Unsigned_Mode ? c : v_s);
        capture = bus.In_Valid & ~bus.Flags_Write;
    end

    always_comb begin
        flags_d  = flags_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        valid_d  = capture;

        if (bus.Flags_Write)
            flags_d = bus.Flags_In;
        else if (bus.In_Valid)
            flags_d = {z, n, c, v};

        if (bus.Clear_Sticky) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end

        // A new event in the clear cycle still counts.
        if (capture && v) begin
            sticky_d = 1'b1;
            if (count_d != COUNT_MAX)
                count_d = count_d + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            flags_q  <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.Zero            = flags_q[3];
    assign bus.Negative        = flags_q[2];
    assign bus.Carry           = flags_q[1];
    assign bus.Overflow        = flags_q[0];
    assign bus.Overflow_Sticky = sticky_q;
    assign bus.Overflow_Count  = count_q;
    assign bus.Out_Valid       = valid_q;
endmodule

// File: tb/tb_flag_status_register.sv
// Directed bench for flag_status_register at WIDTH=8,
// COUNT_WIDTH=2; status packed as {ov, Z,N,C,V, sticky, cnt}.
module tb_flag_status_register;
    logic Clock;
    logic Reset;
    int   tests;
    int   failed;

    flag_status_register_if #(
        .WIDTH(8),
        .COUNT_WIDTH(2)
    ) bus ();

    flag_status_register #(
        .WIDTH(8),
        .COUNT_WIDTH(2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] status();
        return {bus.Out_Valid, bus.Zero, bus.Negative,
                bus.Carry, bus.Overflow,
                bus.Overflow_Sticky, bus.Overflow_Count};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.In_Valid     = 1'b0;
        bus.Flags_Write  = 1'b0;
        bus.Clear_Sticky = 1'b0;
    endtask

    task automatic op(input logic en, input logic sub,
                      input logic um, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] r,
                      input logic co);
        bus.In_Valid          = 1'b1;
        bus.Enable            = en;
        bus.Selection_Sum_Sub = sub;
        bus.Unsigned_Mode     = um;
        bus.Operand_A         = a;
        bus.Operand_B         = b;
        bus.Result            = r;
        bus.Carry_Out         = co;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        tick();
        tick();
        tests++;
        if (status() !== 8'b0_0000_0_00) begin
            failed++;
            $display("FAIL reset: got %b want %b",
                     status(), 8'b0_0000_0_00);
        end
        Reset = 1'b0;
        idle();
    endtask

    task automatic test_sum_signed();
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0101_1_01) begin
            failed++;
            $display("FAIL sum_signed: got %b want %b",
                     status(), 8'b1_0101_1_01);
        end
        idle();
        tick();
        tests++;
        if (status() !== 8'b0_0101_1_01) begin
            failed++;
            $display("FAIL hold_after_op: got %b want %b",
                     status(), 8'b0_0101_1_01);
        end
    endtask

    task automatic test_sub_modes();
        op(1, 1, 0, 8'h00, 8'h01, 8'hFF, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0110_1_01) begin
            failed++;
            $display("FAIL sub_signed: got %b want %b",
                     status(), 8'b1_0110_1_01);
        end
        op(1, 1, 1, 8'h00, 8'h01, 8'hFF, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0111_1_10) begin
            failed++;
            $display("FAIL sub_unsigned: got %b want %b",
                     status(), 8'b1_0111_1_10);
        end
        idle();
    endtask

    task automatic test_enable_off();
        op(0, 0, 0, 8'h80, 8'h80, 8'h00, 1);
        tick();
        tests++;
        if (status() !== 8'b1_1000_1_10) begin
            failed++;
            $display("FAIL enable_off: got %b want %b",
                     status(), 8'b1_1000_1_10);
        end
        op(1, 0, 1, 8'hFF, 8'hFF, 8'hFE, 1);
        bus.In_Valid = 1'b0;
        tick();
        tests++;
        if (status() !== 8'b0_1000_1_10) begin
            failed++;
            $display("FAIL ignore_invalid: got %b want %b",
                     status(), 8'b0_1000_1_10);
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [1:0] want_cnt [5];
        want_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.Clear_Sticky = 1'b1;
        tick();
        tests++;
        if (status() !== 8'b0_1000_0_00) begin
            failed++;
            $display("FAIL clear_sticky: got %b want %b",
                     status(), 8'b0_1000_0_00);
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
            tick();
            tests++;
            if (status() !== {6'b1_0101_1, want_cnt[i]}) begin
                failed++;
                $display("FAIL saturate[%0d]: got %b want %b",
                         i, status(),
                         {6'b1_0101_1, want_cnt[i]});
            end
        end
        bus.Clear_Sticky = 1'b1;
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0101_1_01) begin
            failed++;
            $display("FAIL clear_with_event: got %b want %b",
                     status(), 8'b1_0101_1_01);
        end
        idle();
    endtask

    task automatic test_flags_write();
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        bus.Flags_Write = 1'b1;
        bus.Flags_In    = 4'b1010;
        tick();
        tests++;
        if (status() !== 8'b0_1010_1_01) begin
            failed++;
            $display("FAIL flags_write: got %b want %b",
                     status(), 8'b0_1010_1_01);
        end
        idle();
        tick();
        tests++;
        if (status() !== 8'b0_1010_1_01) begin
            failed++;
            $display("FAIL flags_hold: got %b want %b",
                     status(), 8'b0_1010_1_01);
        end
    endtask

    task automatic test_back_to_back();
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0101_1_10) begin
            failed++;
            $display("FAIL stream_first: got %b want %b",
                     status(), 8'b1_0101_1_10);
        end
        Reset = 1'b1;
        op(1, 0, 0, 8'h7F, 8'h01, 8'h80, 0);
        tick();
        tests++;
        if (status() !== 8'b0_0000_0_00) begin
            failed++;
            $display("FAIL mid_reset: got %b want %b",
                     status(), 8'b0_0000_0_00);
        end
        Reset = 1'b0;
        op(1, 0, 0, 8'h01, 8'h01, 8'h02, 0);
        tick();
        tests++;
        if (status() !== 8'b1_0000_0_00) begin
            failed++;
            $display("FAIL post_reset_op: got %b want %b",
                     status(), 8'b1_0000_0_00);
        end
        op(1, 0, 0, 8'hFF, 8'h01, 8'h00, 1);
        tick();
        tests++;
        if (status() !== 8'b1_1010_0_00) begin
            failed++;
            $display("FAIL throughput: got %b want %b",
                     status(), 8'b1_1010_0_00);
        end
        idle();
        tick();
        tests++;
        if (status() !== 8'b0_1010_0_00) begin
            failed++;
            $display("FAIL valid_drop: got %b want %b",
                     status(), 8'b0_1010_0_00);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        Reset  = 1'b1;
        idle();
        bus.Flags_In = 4'b0000;
        op(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        bus.In_Valid = 1'b0;
        test_reset();
        test_sum_signed();
        test_sub_modes();
        test_enable_off();
        test_saturation();
        test_flags_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed",
                 tests, failed);
        $finish;
    end
endmodule

// File: doc/flag_status_register.md
# flag_status_register

Parametrised, registered successor to the ALU flag detector. It captures Zero, Negative, Carry/Borrow and Overflow for a WIDTH-bit ALU result one cycle after a valid handshake, and supports both signed and unsigned overflow modes. It also keeps a sticky overflow bit and a saturating overflow-event counter for software, and allows a direct flag load for context restore. It sits between the ALU output and the control unit / branch logic.

## Interface
- WIDTH, 32, operand/result width in bits (>= 2)
- COUNT_WIDTH, 8, width of the overflow-event counter (>= 1)

- Clock  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- In_Valid  input  1  Operand_A/Operand_B/Result/Carry_Out valid this cycle
- Enable  input  1  1 = arithmetic op, overflow/carry evaluated; 0 = non-arithmetic op, Carry and Overflow forced 0
- Selection_Sum_Sub  input  1  0 = sum, 1 = subtraction (A − B computed as A + ~B + 1)
- Unsigned_Mode  input  1  0 = Overflow is signed overflow; 1 = Overflow is unsigned carry/borrow
- Operand_A  input  WIDTH  ALU operand A
- Operand_B  input  WIDTH  ALU operand B (uninverted)
- Result  input  WIDTH  ALU result
- Carry_Out  input  1  raw carry out of the ALU adder MSB
- Flags_Write  input  1  load Flags_In into Zero/Negative/Carry/Overflow
- Flags_In  input  4  {Zero, Negative, Carry, Overflow} load value
- Clear_Sticky  input  1  clear Overflow_Sticky and Overflow_Count
- Out_Valid  output  1  flags updated from an ALU op last cycle
- Zero, Negative, Carry, Overflow  output  1 each  registered flags
- Overflow_Sticky  output  1  set by any captured Overflow = 1
- Overflow_Count  output  COUNT_WIDTH  number of captured overflows, saturating

## Operation
- Combinational evaluation (sA = Operand_A[WIDTH-1], sB = Operand_B[WIDTH-1], sR = Result[WIDTH-1]):
  - z = (Result == 0); n = sR
  - c = Enable & (Selection_Sum_Sub ? ~Carry_Out : Carry_Out); for subtraction this is a borrow.
  - sum: v_s = sA == sB and sR != sA.
  - sub: v_s = sA != sB and sR != sA.
  - v = Enable & (Unsigned_Mode ? c : v_s)
- Update priority per cycle: Reset > Flags_Write > In_Valid. Lower-priority requests in that cycle are dropped.
- Capture (In_Valid & ~Flags_Write): {Zero, Negative, Carry, Overflow} <= {z, n, c, v}.
  - If v = 1: Overflow_Sticky <= 1 and Overflow_Count increments.
- Flags_Write: flags <= Flags_In. Flags_Write never affects the sticky bit or the counter.
- No update: all flags hold.
- Counter saturates at 2^COUNT_WIDTH − 1; it never wraps.
- Clear_Sticky is independent of flag priority. When Clear_Sticky and a captured overflow occur in the same cycle, the new event wins: Sticky = 1 and Count = 1.
- Clear_Sticky is ignored under Reset; Reset already clears both.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- Out_Valid <= In_Valid & ~Flags_Write & ~Reset. It is high for exactly one cycle per accepted op and is never asserted for a Flags_Write load.
- There is no backpressure: In_Valid may be asserted every cycle (full throughput).
- Reset values: Zero = 0, Negative = 0, Carry = 0, Overflow = 0, Overflow_Sticky = 0, Overflow_Count = 0, Out_Valid = 0.
- Reset mid-stream: an op presented in the reset cycle is lost, and Out_Valid is 0 in the next cycle.
- Inputs are ignored when In_Valid = 0, including when Enable changes.

## Test plan
- WIDTH=8, sum, signed: A=0x7F, B=0x01, R=0x80, Carry_Out=0 -> next cycle N=1, V=1, C=0, Z=0, Sticky=1, Count=1, Out_Valid=1.
- Sub, signed vs unsigned: A=0x00, B=0x01, R=0xFF, Carry_Out=0.
  - Unsigned_Mode=0 -> V=0, C=1.
  - Unsigned_Mode=1 -> V=1, C=1.
- Enable=0 with A=0x80, B=0x80, R=0x00, Carry_Out=1 -> Z=1, C=0, V=0, Count unchanged.
- COUNT_WIDTH=2: 5 consecutive overflowing ops -> Count steps 1, 2, 3, 3, 3. Then Clear_Sticky together with a 6th overflow -> Count=1, Sticky=1.
- Flags_Write with Flags_In=4'b1010 plus In_Valid in the same cycle -> Z=1, N=0, C=1, V=0; Out_Valid=0; Count unchanged.
- Reset asserted in the middle of a back-to-back In_Valid stream -> all outputs 0 after the reset edge; the first valid op after Reset deasserts produces Out_Valid exactly one cycle later.
